// File: rtl/bank_ram_copy_pkg.sv
// Shared constants, FSM state type and width helpers for the bank RAM copy master.
package bank_ram_copy_pkg;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single bank still needs one select bit on the ports.
  function automatic int bank_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bank_ram_copy_fifo.sv
// Synchronous skid FIFO holding read data until the matching write is accepted.
module bank_ram_copy_fifo
  import bank_ram_copy_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bank_ram_copy_master.sv
// Copies a run of words from one RAM bank to another over a shared command bus,
// limiting outstanding reads with credits and buffering returns in a skid FIFO.
module bank_ram_copy_master
  import bank_ram_copy_pkg::*;
#(
  parameter int NUM_BANKS       = 5,
  parameter int ADDR_WIDTH      = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [bank_width(NUM_BANKS)-1:0] src_bank,
  input  logic [bank_width(NUM_BANKS)-1:0] dst_bank,
  input  logic [ADDR_WIDTH-1:0]            src_addr,
  input  logic [ADDR_WIDTH-1:0]            dst_addr,
  input  logic [LEN_WIDTH-1:0]             len,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic                             cmd_we,
  output logic [bank_width(NUM_BANKS)-1:0] cmd_bank,
  output logic [ADDR_WIDTH-1:0]            cmd_addr,
  output logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic                             rd_valid,
  input  logic [DATA_WIDTH-1:0]            rd_data
);

  localparam int BW = bank_width(NUM_BANKS);
  localparam int CW = count_width(MAX_OUTSTANDING);

  state_t                state;
  state_t                state_nxt;
  logic [BW-1:0]         src_bank_q;
  logic [BW-1:0]         dst_bank_q;
  logic [ADDR_WIDTH-1:0] src_addr_q;
  logic [ADDR_WIDTH-1:0] dst_addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  reads_issued;
  logic [LEN_WIDTH-1:0]  writes_done;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  hold_valid;
  logic                  hold_we;
  logic                  err_q;
  logic                  banks_ok;
  logic                  accept;
  logic                  rd_elig;
  logic                  wr_elig;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  rd_push;
  logic                  last_wr;

  assign banks_ok = ({1'b0, src_bank} < (BW + 1)'(NUM_BANKS)) &&
                    ({1'b0, dst_bank} < (BW + 1)'(NUM_BANKS));
  assign accept   = (state == IDLE) && start && banks_ok;
  assign rd_push  = (state == RUN) && rd_valid;

  // Credits cover both beats still on the bus and beats parked in the FIFO.
  assign rd_elig  = (state == RUN) && (reads_issued < len_q) &&
                    (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(MAX_OUTSTANDING));
  assign wr_elig  = (state == RUN) && !fifo_empty;

  assign rd_acc   = cmd_valid && cmd_ready && (cmd_we == CMD_RD);
  assign wr_acc   = cmd_valid && cmd_ready && (cmd_we == CMD_WR);
  assign last_wr  = wr_acc && (writes_done == len_q - LEN_WIDTH'(1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q;

  // A stalled command keeps its type; otherwise writes take priority to free credits.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_we    = CMD_RD;
    cmd_bank  = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    if (state == RUN) begin
      if (hold_valid) begin
        cmd_valid = 1'b1;
        cmd_we    = hold_we;
      end else if (wr_elig) begin
        cmd_valid = 1'b1;
        cmd_we    = CMD_WR;
      end else if (rd_elig) begin
        cmd_valid = 1'b1;
        cmd_we    = CMD_RD;
      end
    end
    if (cmd_valid) begin
      if (cmd_we == CMD_WR) begin
        cmd_bank  = dst_bank_q;
        cmd_addr  = dst_addr_q;
        cmd_wdata = fifo_head;
      end else begin
        cmd_bank  = src_bank_q;
        cmd_addr  = src_addr_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_wr) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      src_bank_q   <= '0;
      dst_bank_q   <= '0;
      src_addr_q   <= '0;
      dst_addr_q   <= '0;
      len_q        <= '0;
      reads_issued <= '0;
      writes_done  <= '0;
      inflight     <= '0;
      hold_valid   <= 1'b0;
      hold_we      <= CMD_RD;
      err_q        <= 1'b0;
    end else begin
      err_q      <= (state == IDLE) && start && !banks_ok;
      hold_valid <= (state == RUN) && cmd_valid && !cmd_ready;
      hold_we    <= cmd_we;
      if (accept) begin
        src_bank_q   <= src_bank;
        dst_bank_q   <= dst_bank;
        src_addr_q   <= src_addr;
        dst_addr_q   <= dst_addr;
        len_q        <= len;
        reads_issued <= '0;
        writes_done  <= '0;
        inflight     <= '0;
      end else if (state == RUN) begin
        if (rd_acc) begin
          src_addr_q   <= src_addr_q + ADDR_WIDTH'(1);
          reads_issued <= reads_issued + LEN_WIDTH'(1);
        end
        if (wr_acc) begin
          dst_addr_q  <= dst_addr_q + ADDR_WIDTH'(1);
          writes_done <= writes_done + LEN_WIDTH'(1);
        end
        case ({rd_acc, rd_push})
          2'b10:   inflight <= inflight + CW'(1);
          2'b01:   inflight <= inflight - CW'(1);
          default: ;
        endcase
      end
    end
  end

  bank_ram_copy_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (rd_push),
    .wdata(rd_data),
    .pop  (wr_acc),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // The credit rule guarantees space for every returning beat.
  assert property (@(posedge clk) disable iff (!rstn) !(rd_push && fifo_full));

endmodule

// File: tb/tb_bank_ram_copy_master.sv
// Scoreboard bench: a bus/RAM model answers commands while a monitor checks them
// against expectations derived from the copy request.
module tb_bank_ram_copy_master;

  localparam int NB = 5;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LW = 10;
  localparam int MO = 4;
  localparam int DEPTH_WORDS = 512;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [2:0]    src_bank;
  logic [2:0]    dst_bank;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          err;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [2:0]    cmd_bank;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  typedef struct {
    int          bank;
    int          addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] mem [NB][DEPTH_WORDS];
  cmd_t        exp_rd[$];
  cmd_t        exp_wr[$];
  ret_t        ret_q[$];

  int compared = 0;
  int mismatched = 0;
  int pcyc = 0;
  int rd_lat = 2;
  int ready_pct = 100;
  int rd_hs = 0;
  int wr_hs = 0;
  int credit = 0;
  int valid_cycles = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_wr_pcyc = 0;

  bank_ram_copy_master dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .src_bank (src_bank),
    .dst_bank (dst_bank),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_bank (cmd_bank),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Bus model and monitor: drives ready/returns for the next edge and scores handshakes.
  initial begin : bus_monitor
    cmd_t        e;
    logic        stalled_prev;
    logic [44:0] prev_fields;
    stalled_prev = 1'b0;
    prev_fields  = '0;
    cmd_ready    = 1'b0;
    rd_valid     = 1'b0;
    rd_data      = '0;
    forever begin
      @(negedge clk);
      if (ret_q.size() > 0 && ret_q[0].due <= pcyc) begin
        rd_valid = 1'b1;
        rd_data  = ret_q[0].data;
        void'(ret_q.pop_front());
      end else begin
        rd_valid = 1'b0;
        rd_data  = $urandom;
      end
      cmd_ready = ($urandom_range(0, 99) < ready_pct);
      if (!rstn) begin
        stalled_prev = 1'b0;
        continue;
      end
      if (stalled_prev) begin
        checkOutput("stall_valid_held", 64'(cmd_valid), 64'd1);
        checkOutput("stall_fields_held", 64'({cmd_we, cmd_bank, cmd_addr, cmd_wdata}), 64'(prev_fields));
      end
      if (cmd_valid) valid_cycles++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (cmd_valid && cmd_ready) begin
        if (cmd_we) begin
          wr_hs++;
          credit--;
          last_wr_pcyc = pcyc;
          if (exp_wr.size() == 0) begin
            checkOutput("unexpected_write", 64'd1, 64'd0);
          end else begin
            e = exp_wr.pop_front();
            checkOutput("wr_bank", 64'(cmd_bank), 64'(e.bank));
            checkOutput("wr_addr", 64'(cmd_addr), 64'(e.addr));
            checkOutput("wr_data", 64'(cmd_wdata), 64'(e.data));
          end
          if (cmd_bank < NB) mem[cmd_bank][cmd_addr] = cmd_wdata;
        end else begin
          rd_hs++;
          credit++;
          if (exp_rd.size() == 0) begin
            checkOutput("unexpected_read", 64'd1, 64'd0);
          end else begin
            e = exp_rd.pop_front();
            checkOutput("rd_bank", 64'(cmd_bank), 64'(e.bank));
            checkOutput("rd_addr", 64'(cmd_addr), 64'(e.addr));
            checkOutput("rd_wdata_zero", 64'(cmd_wdata), 64'd0);
          end
          checkOutput("credits_within_limit", 64'(credit <= MO), 64'd1);
          ret_q.push_back('{pcyc + rd_lat, (cmd_bank < NB) ? mem[cmd_bank][cmd_addr] : 32'h0});
        end
      end
      stalled_prev = cmd_valid && !cmd_ready;
      prev_fields  = {cmd_we, cmd_bank, cmd_addr, cmd_wdata};
    end
  end

  // Issues one copy request; abort_after > 0 pulses reset that many cycles into the copy.
  task automatic applyStimulus(input int sb, input int db, input int sa, input int da,
                               input int ln, input int lat, input int rpct, input int abort_after);
    logic [31:0] snap[$];
    int rd0, wr0, v0, d0, e0, spc, k, a;
    bit valid_req;
    rd_lat    = lat;
    ready_pct = rpct;
    valid_req = (sb < NB) && (db < NB);
    @(negedge clk);
    if (valid_req) begin
      for (int i = 0; i < ln; i++) begin
        a = (sa + i) % DEPTH_WORDS;
        snap.push_back(mem[sb][a]);
        exp_rd.push_back('{sb, a, 32'h0});
        exp_wr.push_back('{db, (da + i) % DEPTH_WORDS, mem[sb][a]});
      end
    end
    credit = 0;
    rd0 = rd_hs; wr0 = wr_hs; v0 = valid_cycles; d0 = done_cnt; e0 = err_cnt;
    start    = 1'b1;
    src_bank = 3'(sb);
    dst_bank = 3'(db);
    src_addr = AW'(sa);
    dst_addr = AW'(da);
    len      = LW'(ln);
    @(negedge clk);
    start    = 1'b0;
    src_bank = 3'($urandom);
    dst_bank = 3'($urandom);
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    len      = LW'($urandom);
    spc      = pcyc;
    if (!valid_req) begin
      checkOutput("err_pulse", 64'(err), 64'd1);
      checkOutput("err_busy_low", 64'(busy), 64'd0);
      repeat (4) @(negedge clk);
      checkOutput("err_single_pulse", 64'(err_cnt - e0), 64'd1);
      checkOutput("err_no_commands", 64'(valid_cycles - v0), 64'd0);
      checkOutput("err_no_done", 64'(done_cnt - d0), 64'd0);
      checkOutput("err_busy_stays_low", 64'(busy), 64'd0);
      return;
    end
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    if (ln == 0) begin
      checkOutput("len0_done_next_cycle", 64'(done), 64'd1);
      checkOutput("len0_no_cmd_valid", 64'(cmd_valid), 64'd0);
    end else begin
      checkOutput("first_read_valid", 64'(cmd_valid), 64'd1);
      checkOutput("first_read_type", 64'(cmd_we), 64'd0);
    end
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_err", 64'(err), 64'd0);
      checkOutput("abort_cmd_valid", 64'(cmd_valid), 64'd0);
      checkOutput("abort_cmd_we", 64'(cmd_we), 64'd0);
      checkOutput("abort_cmd_bank", 64'(cmd_bank), 64'd0);
      checkOutput("abort_cmd_addr", 64'(cmd_addr), 64'd0);
      checkOutput("abort_cmd_wdata", 64'(cmd_wdata), 64'd0);
      exp_rd.delete();
      exp_wr.delete();
      rstn = 1'b1;
      k = 0;
      while (ret_q.size() > 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", 64'(done_cnt - d0), 64'd0);
      checkOutput("abort_idle", 64'(busy), 64'd0);
      return;
    end
    k = 0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
    end else begin
      checkOutput("busy_in_done_cycle", 64'(busy), 64'd1);
      if (ln > 0) begin
        checkOutput("done_after_last_write", 64'(pcyc - last_wr_pcyc), 64'd1);
        if (rpct == 100 && lat <= 2)
          checkOutput("throughput_bound", 64'((pcyc - spc) <= 2 * ln + 8), 64'd1);
      end
    end
    @(negedge clk);
    checkOutput("busy_clear", 64'(busy), 64'd0);
    checkOutput("done_clear", 64'(done), 64'd0);
    checkOutput("done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("read_count", 64'(rd_hs - rd0), 64'(ln));
    checkOutput("write_count", 64'(wr_hs - wr0), 64'(ln));
    checkOutput("reads_pending", 64'(exp_rd.size()), 64'd0);
    checkOutput("writes_pending", 64'(exp_wr.size()), 64'd0);
    if (ln == 0) checkOutput("len0_no_commands", 64'(valid_cycles - v0), 64'd0);
    for (int i = 0; i < ln; i++) begin
      checkOutput("dst_contents", 64'(mem[db][(da + i) % DEPTH_WORDS]), 64'(snap[i]));
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int sb, db;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH_WORDS; a++)
        mem[b][a] = $urandom;
    rstn     = 1'b0;
    start    = 1'b0;
    src_bank = '0;
    dst_bank = '0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("reset_cmd_we", 64'(cmd_we), 64'd0);
    checkOutput("reset_cmd_bank", 64'(cmd_bank), 64'd0);
    checkOutput("reset_cmd_addr", 64'(cmd_addr), 64'd0);
    checkOutput("reset_cmd_wdata", 64'(cmd_wdata), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] copy 8 words bank0@0x010 -> bank3@0x100");
    applyStimulus(0, 3, 'h010, 'h100, 8, 2, 100, 0);
    $display("[TB] zero-length request");
    applyStimulus(1, 2, 'h000, 'h000, 0, 2, 100, 0);
    $display("[TB] invalid source and destination banks");
    applyStimulus(5, 1, 'h000, 'h000, 4, 2, 100, 0);
    applyStimulus(2, 7, 'h000, 'h000, 4, 2, 100, 0);
    $display("[TB] address wrap at the top of the bank");
    applyStimulus(1, 2, 'h1FE, 'h1FF, 4, 2, 100, 0);
    $display("[TB] random stalls with slow read return");
    applyStimulus(2, 4, 'h050, 'h0A0, 20, 6, 50, 0);
    $display("[TB] reset mid-copy, then fresh copy");
    applyStimulus(3, 1, 'h020, 'h030, 16, 3, 80, 6);
    applyStimulus(3, 1, 'h020, 'h030, 16, 3, 80, 0);
    $display("[TB] random copies");
    for (int t = 0; t < 6; t++) begin
      sb = $urandom_range(0, NB - 1);
      db = (sb + $urandom_range(1, NB - 1)) % NB;
      applyStimulus(sb, db, $urandom_range(0, 511), $urandom_range(0, 511),
                    $urandom_range(1, 24), $urandom_range(1, 6), $urandom_range(30, 100), 0);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
